// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC waveform sequencer.
// Holds the mode encoding, the mode count and the wave() sample function.
// The bench imports this package as well, so wave() has a single definition.
package dac_seq_pkg;

    localparam int unsigned SAMPLE_W   = 8;
    localparam int unsigned MODE_W     = 2;
    localparam int unsigned MODE_COUNT = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF = 2'd0,
        MODE_SAW = 2'd1,
        MODE_TRI = 2'd2,
        MODE_SQR = 2'd3
    } mode_e;

    // One waveform sample for the given mode at the given phase.
    function automatic logic [SAMPLE_W-1:0] wave(
        input mode_e               mode,
        input logic [SAMPLE_W-1:0] phase,
        input logic [SAMPLE_W-1:0] midscale
    );
        logic [SAMPLE_W-1:0] ramp;
        logic [SAMPLE_W-1:0] sample;
        // Doubled phase: rises over the first half-period, mirrored in the second.
        ramp = {phase[SAMPLE_W-2:0], 1'b0};
        case (mode)
            MODE_OFF: sample = midscale;
            MODE_SAW: sample = phase;
            MODE_TRI: sample = phase[SAMPLE_W-1] ? ~ramp : ramp;
            MODE_SQR: sample = phase[SAMPLE_W-1] ? '1 : '0;
            default:  sample = midscale;
        endcase
        return sample;
    endfunction

endpackage

// File: rtl/sample_tick_divider.sv
// Sample-rate divider: counts 0..CLKS_PER_SAMPLE-1 and flags the last count.
// Ports:
//   i_Clk    system clock
//   i_Reset  synchronous active-high reset, count returns to 0
//   i_Clear  restarts the count at 0 on the next cycle (mode edge)
//   o_Tick   high while the count sits at CLKS_PER_SAMPLE-1
module sample_tick_divider #(
    parameter int unsigned CLKS_PER_SAMPLE = 250
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Clear,
    output logic o_Tick
);

    localparam int unsigned    CNT_W = $clog2(CLKS_PER_SAMPLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_SAMPLE - 1);

    logic [CNT_W-1:0] count;

    assign o_Tick = (count == LAST);

    // Free-running counter, wrapped on the tick and restarted by a clear.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            count <= '0;
        end else if (o_Tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dac_waveform_sequencer.sv
// Plays a selectable waveform into the 8-bit PMOD DAC driver.
// A divided sample tick advances an 8-bit phase accumulator; each tick one
// wave() sample is registered onto o_Dac_Byte and a strobe follows a cycle
// later. Rising edges of the debounced switch step the mode OFF->SAW->TRI->SQR.
// Ports:
//   i_Clk            system clock
//   i_Reset          synchronous active-high reset
//   i_Mode_Switch    debounced switch level, rising edge advances the mode
//   i_Step           phase increment applied on each tick
//   o_Dac_Byte       registered sample to the DAC driver
//   o_Sample_Strobe  one-cycle pulse the cycle after o_Dac_Byte updates
//   o_Mode           current mode (0 OFF, 1 SAW, 2 TRI, 3 SQR)
module dac_waveform_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned CLKS_PER_SAMPLE = 250,
    parameter logic [7:0]  MIDSCALE        = 8'h80
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Mode_Switch,
    input  logic [7:0] i_Step,
    output logic [7:0] o_Dac_Byte,
    output logic       o_Sample_Strobe,
    output logic [1:0] o_Mode
);

    mode_e               mode;
    mode_e               mode_next;
    logic                switch_prev;
    logic                mode_edge;
    logic                tick;
    logic                sample_done;
    logic [SAMPLE_W-1:0] phase;

    // Reset value 1 keeps a switch held through reset from counting as an edge.
    assign mode_edge = i_Mode_Switch & ~switch_prev;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            switch_prev <= 1'b1;
        end else begin
            switch_prev <= i_Mode_Switch;
        end
    end

    // Sample-rate divider, restarted by every mode edge.
    sample_tick_divider #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_divider (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Clear (mode_edge),
        .o_Tick  (tick)
    );

    // Mode state register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            mode <= MODE_OFF;
        end else begin
            mode <= mode_next;
        end
    end

    // Mode next-state: cycles through the four modes on each switch edge.
    always_comb begin
        mode_next = mode;
        if (mode_edge) begin
            case (mode)
                MODE_OFF: mode_next = MODE_SAW;
                MODE_SAW: mode_next = MODE_TRI;
                MODE_TRI: mode_next = MODE_SQR;
                MODE_SQR: mode_next = MODE_OFF;
                default:  mode_next = MODE_OFF;
            endcase
        end
    end

    // Phase accumulator and output registers. An edge wins over a coincident
    // tick: it restarts the phase and suppresses that tick's sample.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            phase           <= '0;
            o_Dac_Byte      <= MIDSCALE;
            sample_done     <= 1'b0;
            o_Sample_Strobe <= 1'b0;
        end else begin
            o_Sample_Strobe <= sample_done;
            sample_done     <= 1'b0;
            if (mode_edge) begin
                phase <= '0;
            end else if (tick) begin
                o_Dac_Byte  <= wave(mode, phase, MIDSCALE);
                phase       <= phase + i_Step;
                sample_done <= 1'b1;
            end
        end
    end

    assign o_Mode = mode;

endmodule

// File: tb/tb_dac_waveform_sequencer.sv
// Scoreboard bench for dac_waveform_sequencer with CLKS_PER_SAMPLE = 4.
// Stimulus pushes (byte, strobe cycle) expectations; a monitor pops one per strobe.
module tb_dac_waveform_sequencer;
    import dac_seq_pkg::*;

    localparam int unsigned CLKS    = 4;
    localparam int          TIMEOUT = 200;
    // Tick lands CLKS cycles after an edge cycle; the strobe trails the tick by 2.
    localparam int          EDGE_TO_STROBE    = CLKS + 2;
    // Count is 0 in the release cycle; the tick is at CLKS-1, strobe 2 later.
    localparam int          RELEASE_TO_STROBE = CLKS + 1;

    localparam logic [7:0] SAW_EXP [5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    localparam logic [7:0] TRI_EXP [8] = '{8'h00, 8'h40, 8'h80, 8'hC0,
                                           8'hFF, 8'hBF, 8'h7F, 8'h3F};
    localparam logic [7:0] SQR_EXP [8] = '{8'h00, 8'h00, 8'h00, 8'h00,
                                           8'hFF, 8'hFF, 8'hFF, 8'hFF};

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       sw;
    logic [7:0] step;
    logic [7:0] dac;
    logic       strobe;
    logic [1:0] mode;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    dac_waveform_sequencer #(
        .CLKS_PER_SAMPLE(CLKS),
        .MIDSCALE       (8'h80)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Mode_Switch  (sw),
        .i_Step         (step),
        .o_Dac_Byte     (dac),
        .o_Sample_Strobe(strobe),
        .o_Mode         (mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expectation in byte and cycle.
    always @(posedge clk) begin
        #1;
        if (mon_en && strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe with byte %0h at cycle %0d, expected none",
                         dac, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sample_byte", 32'(dac), 32'(e.data));
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d samples pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Holds reset for n clock edges; r is the first cycle with reset low.
    task automatic do_reset(input int n, output int r);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        r = cyc;
    endtask

    // One-cycle switch pulse; e is the edge cycle. Returns two cycles later.
    task automatic press(input logic [1:0] exp_mode, output int e);
        sw = 1'b1;
        e  = cyc;
        @(negedge clk);
        sw = 1'b0;
        check("mode_after_edge", 32'(mode), 32'(exp_mode));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int e;
        rst  = 1'b1;
        sw   = 1'b0;
        step = 8'd0;

        // 1: reset values, first strobe 5 cycles after release
        do_reset(3, r);
        mon_en = 1'b1;
        check("reset_byte", 32'(dac), 32'h80);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_strobe", 32'(strobe), 32'd0);
        push(8'h80, r + RELEASE_TO_STROBE);
        push(8'h80, r + RELEASE_TO_STROBE + 4);
        drain("reset");

        // 2: sawtooth, step 64, phase wraps
        step = 8'd64;
        press(MODE_SAW, e);
        for (int k = 0; k < 5; k++) push(SAW_EXP[k], e + EDGE_TO_STROBE + 4 * k);
        drain("saw");

        // 3: triangle then square, step 32
        step = 8'd32;
        press(MODE_TRI, e);
        for (int k = 0; k < 8; k++) push(TRI_EXP[k], e + EDGE_TO_STROBE + 4 * k);
        drain("tri");
        press(MODE_SQR, e);
        for (int k = 0; k < 8; k++) push(SQR_EXP[k], e + EDGE_TO_STROBE + 4 * k);
        drain("sqr");

        // 4: edge on the tick cycle (two cycles after the last strobe)
        @(negedge clk);
        @(negedge clk);
        press(MODE_OFF, e);
        check("byte_held_after_edge", 32'(dac), 32'hFF);
        push(8'h80, e + EDGE_TO_STROBE);
        drain("edge_on_tick");
        for (int i = 0; i < MODE_COUNT; i++) press(2'((i + 1) % MODE_COUNT), e);
        check("mode_wrapped", 32'(mode), 32'd0);
        push(8'h80, e + EDGE_TO_STROBE);
        drain("four_edges");

        // 5: switch held through reset gives no edge; a later press gives one
        sw = 1'b1;
        do_reset(3, r);
        check("held_reset_mode", 32'(mode), 32'd0);
        push(8'h80, r + RELEASE_TO_STROBE);
        drain("held_switch");
        check("held_switch_mode", 32'(mode), 32'd0);
        sw = 1'b0;
        @(negedge clk);
        press(MODE_SAW, e);
        push(8'h00, e + EDGE_TO_STROBE);
        push(8'h20, e + EDGE_TO_STROBE + 4);
        drain("press_after_held");
        check("single_advance_mode", 32'(mode), 32'd1);

        // 6: reset mid-stream in SQR with phase at A0
        press(MODE_TRI, e);
        press(MODE_SQR, e);
        for (int k = 0; k < 5; k++) push(SQR_EXP[k], e + EDGE_TO_STROBE + 4 * k);
        drain("sqr_to_a0");
        do_reset(1, r);
        check("midreset_byte", 32'(dac), 32'h80);
        check("midreset_mode", 32'(mode), 32'd0);
        check("midreset_strobe", 32'(strobe), 32'd0);
        push(8'h80, r + RELEASE_TO_STROBE);
        drain("after_midreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
